exec_muldiv: RTL and testbench

Multi-cycle RV32M execute-stage unit that sits directly downstream of the decode/execute pipeline register, alongside the ALU. It consumes the forwarded execute-stage operands and funct3 of an M-extension instruction, stalls the front of the pipeline while it iterates, and presents a one-cycle-valid result for the execute/memory register to capture. Multiplies complete in a fixed short latency. Divides use a 32-iteration radix-2 restoring algorithm, with early exit for divide-by-zero and signed overflow.

---
 rtl/muldiv_pkg.sv | 28 ++
 rtl/div_core.sv | 63 ++++++
 rtl/exec_muldiv.sv | 181 ++++++++++++++++++
 tb/tb_exec_muldiv.sv | 281 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/muldiv_pkg.sv
// Shared types and constants for the RV32M execute-stage multiply/divide unit.
package muldiv_pkg;

    // funct3 encoding of the M-extension ops
    typedef enum logic [2:0] {
        OP_MUL    = 3'd0,
        OP_MULH   = 3'd1,
        OP_MULHSU = 3'd2,
        OP_MULHU  = 3'd3,
        OP_DIV    = 3'd4,
        OP_DIVU   = 3'd5,
        OP_REM    = 3'd6,
        OP_REMU   = 3'd7
    } md_op_e;

    // Sequencer states
    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_MUL  = 2'd1,
        S_DIV  = 2'd2,
        S_DONE = 2'd3
    } md_state_e;

    localparam int         DIV_ITERS = 32;
    localparam logic [6:0] OPCODE_OP = 7'b0110011;
    localparam logic [6:0] FUNCT7_M  = 7'b0000001;

endpackage

// File: rtl/div_core.sv
// Unsigned radix-2 restoring divider: one quotient bit per step.
// quotient/remainder present the values the registers take if a step is
// applied this cycle, so the caller can capture the final result on the
// same edge as the last step.
module div_core
    import muldiv_pkg::*;
#(
    parameter int DATA_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  load,
    input  logic                  step,
    input  logic [DATA_WIDTH-1:0] dividend,
    input  logic [DATA_WIDTH-1:0] divisor,
    output logic [DATA_WIDTH-1:0] quotient,
    output logic [DATA_WIDTH-1:0] remainder,
    output logic                  last
);

    logic [DATA_WIDTH-1:0] rem_q;
    logic [DATA_WIDTH-1:0] quo_q;
    logic [DATA_WIDTH-1:0] dvs_q;
    logic [5:0]            cnt_q;

    logic [DATA_WIDTH:0]   shifted;
    logic [DATA_WIDTH:0]   diff;
    logic                  fits;

    // Trial subtraction of the divisor from the partial remainder shifted
    // left by one with the next dividend bit brought in.
    always_comb begin
        shifted   = {rem_q, quo_q[DATA_WIDTH-1]};
        diff      = shifted - {1'b0, dvs_q};
        fits      = ~diff[DATA_WIDTH];
        quotient  = {quo_q[DATA_WIDTH-2:0], fits};
        remainder = fits ? diff[DATA_WIDTH-1:0] : shifted[DATA_WIDTH-1:0];
    end

    assign last = (cnt_q == 6'(DIV_ITERS - 1));

    // Shift registers and step counter; the counter saturates instead of wrapping.
    always_ff @(posedge clk) begin
        if (!rst) begin
            rem_q <= '0;
            quo_q <= '0;
            dvs_q <= '0;
            cnt_q <= '0;
        end else if (load) begin
            rem_q <= '0;
            quo_q <= dividend;
            dvs_q <= divisor;
            cnt_q <= '0;
        end else if (step) begin
            rem_q <= remainder;
            quo_q <= quotient;
            if (cnt_q != 6'h3F) begin
                cnt_q <= cnt_q + 6'd1;
            end
        end
    end

endmodule

// File: rtl/exec_muldiv.sv
// RV32M execute-stage multiply/divide unit. Multiplies take one MUL cycle,
// normal divides 32 DIV cycles; divide-by-zero and signed overflow skip
// straight to DONE with the architectural result preloaded.
module exec_muldiv
    import muldiv_pkg::*;
#(
    parameter int DATA_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  startE,
    input  logic [2:0]            funct3E,
    input  logic [DATA_WIDTH-1:0] SrcAE,
    input  logic [DATA_WIDTH-1:0] SrcBE,
    input  logic                  killE,
    output logic                  StallMD,
    output logic                  DoneMD,
    output logic [DATA_WIDTH-1:0] ResultMD
);

    md_state_e             state_q, state_d;
    md_op_e                op_q;
    logic [DATA_WIDTH-1:0] a_q, b_q;
    logic                  negq_q, negr_q;
    logic [DATA_WIDTH-1:0] result_q, result_d;
    logic                  result_we;
    logic                  accept;
    logic                  div_load, div_step;

    logic                  is_div, signed_div, is_rem, divz, ovf;
    logic [DATA_WIDTH-1:0] special_val;
    logic [DATA_WIDTH-1:0] dvd_mag, dvs_mag;

    logic signed [63:0]    ext_a, ext_b, prod;
    logic                  sext_a, sext_b;
    logic [DATA_WIDTH-1:0] mul_sel, div_sel;

    logic [DATA_WIDTH-1:0] core_quo, core_rem;
    logic                  core_last;

    // Two's-complement negate when requested (sign fixup of div results).
    function automatic logic [DATA_WIDTH-1:0] fixup(input logic [DATA_WIDTH-1:0] v,
                                                     input logic neg);
        return neg ? (~v + 1'b1) : v;
    endfunction

    // Magnitude of a signed operand; unsigned ops pass through untouched.
    function automatic logic [DATA_WIDTH-1:0] magnitude(input logic [DATA_WIDTH-1:0] v,
                                                         input logic is_signed);
        return (is_signed && v[DATA_WIDTH-1]) ? (~v + 1'b1) : v;
    endfunction

    // Decode and special-case detection on the execute-stage operands.
    always_comb begin
        is_div     = funct3E[2];
        signed_div = ~funct3E[0];
        is_rem     = funct3E[1];
        divz       = (SrcBE == '0);
        ovf        = signed_div && (SrcAE == 32'h8000_0000) && (SrcBE == 32'hFFFF_FFFF);
        if (divz) begin
            special_val = is_rem ? SrcAE : 32'hFFFF_FFFF;
        end else begin
            special_val = is_rem ? 32'h0000_0000 : 32'h8000_0000;
        end
        dvd_mag = magnitude(SrcAE, signed_div);
        dvs_mag = magnitude(SrcBE, signed_div);
    end

    // 33-bit operand extension folded into a 64-bit signed product.
    always_comb begin
        sext_a  = (op_q != OP_MULHU);
        sext_b  = (op_q == OP_MUL) || (op_q == OP_MULH);
        ext_a   = {{32{a_q[DATA_WIDTH-1] & sext_a}}, a_q};
        ext_b   = {{32{b_q[DATA_WIDTH-1] & sext_b}}, b_q};
        prod    = ext_a * ext_b;
        mul_sel = (op_q == OP_MUL) ? prod[31:0] : prod[63:32];
        div_sel = ((op_q == OP_REM) || (op_q == OP_REMU)) ? fixup(core_rem, negr_q)
                                                          : fixup(core_quo, negq_q);
    end

    div_core #(
        .DATA_WIDTH(DATA_WIDTH)
    ) u_div_core (
        .clk       (clk),
        .rst       (rst),
        .load      (div_load),
        .step      (div_step),
        .dividend  (dvd_mag),
        .divisor   (dvs_mag),
        .quotient  (core_quo),
        .remainder (core_rem),
        .last      (core_last)
    );

    // Next state, stall/done outputs and result capture; kill and reset win.
    always_comb begin
        state_d   = state_q;
        StallMD   = 1'b0;
        DoneMD    = 1'b0;
        accept    = 1'b0;
        div_load  = 1'b0;
        div_step  = 1'b0;
        result_we = 1'b0;
        result_d  = result_q;
        case (state_q)
            S_IDLE: begin
                if (startE) begin
                    StallMD = 1'b1;
                    accept  = 1'b1;
                    if (!is_div) begin
                        state_d = S_MUL;
                    end else if (divz || ovf) begin
                        state_d   = S_DONE;
                        result_we = 1'b1;
                        result_d  = special_val;
                    end else begin
                        state_d  = S_DIV;
                        div_load = 1'b1;
                    end
                end
            end
            S_MUL: begin
                StallMD   = 1'b1;
                state_d   = S_DONE;
                result_we = 1'b1;
                result_d  = mul_sel;
            end
            S_DIV: begin
                StallMD  = 1'b1;
                div_step = 1'b1;
                if (core_last) begin
                    state_d   = S_DONE;
                    result_we = 1'b1;
                    result_d  = div_sel;
                end
            end
            S_DONE: begin
                DoneMD  = 1'b1;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
        if (killE || !rst) begin
            state_d   = S_IDLE;
            StallMD   = 1'b0;
            DoneMD    = 1'b0;
            accept    = 1'b0;
            div_load  = 1'b0;
            div_step  = 1'b0;
            result_we = 1'b0;
        end
    end

    // State, latched operands/signs and the held result register.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q  <= S_IDLE;
            op_q     <= OP_MUL;
            a_q      <= '0;
            b_q      <= '0;
            negq_q   <= 1'b0;
            negr_q   <= 1'b0;
            result_q <= '0;
        end else begin
            state_q <= state_d;
            if (accept) begin
                op_q   <= md_op_e'(funct3E);
                a_q    <= SrcAE;
                b_q    <= SrcBE;
                negq_q <= signed_div && (SrcAE[DATA_WIDTH-1] ^ SrcBE[DATA_WIDTH-1]);
                negr_q <= signed_div && SrcAE[DATA_WIDTH-1];
            end
            if (result_we) begin
                result_q <= result_d;
            end
        end
    end

    assign ResultMD = result_q;

endmodule

// File: tb/tb_exec_muldiv.sv
// Bench for exec_muldiv: directed vector table, random ops against an
// arithmetic reference model, and kill / reset / back-to-back sequences.
module tb_exec_muldiv;

    logic        clk;
    logic        rst;
    logic        startE;
    logic [2:0]  funct3E;
    logic [31:0] SrcAE;
    logic [31:0] SrcBE;
    logic        killE;
    logic        StallMD;
    logic        DoneMD;
    logic [31:0] ResultMD;

    int n_checks;
    int n_pass;
    int done_cnt;

    exec_muldiv #(.DATA_WIDTH(32)) dut (
        .clk      (clk),
        .rst      (rst),
        .startE   (startE),
        .funct3E  (funct3E),
        .SrcAE    (SrcAE),
        .SrcBE    (SrcBE),
        .killE    (killE),
        .StallMD  (StallMD),
        .DoneMD   (DoneMD),
        .ResultMD (ResultMD)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (DoneMD === 1'b1) done_cnt++;
    end

    typedef struct {
        logic [2:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] res;
        int          lat;
    } vec_t;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    endtask

    // RV32M semantics computed directly with integer arithmetic.
    function automatic logic [31:0] ref_res(input logic [2:0] op, input logic [31:0] a,
                                            input logic [31:0] b);
        longint      sa, sb, ua, ub;
        logic [63:0] p;
        int          ia, ib;
        sa = $signed(a);
        sb = $signed(b);
        ua = {32'h0, a};
        ub = {32'h0, b};
        ia = $signed(a);
        ib = $signed(b);
        case (op)
            3'd0: begin p = sa * sb; return p[31:0]; end
            3'd1: begin p = sa * sb; return p[63:32]; end
            3'd2: begin p = sa * ub; return p[63:32]; end
            3'd3: begin p = {32'h0, a} * {32'h0, b}; return p[63:32]; end
            3'd4: begin
                if (b == 0) return 32'hFFFF_FFFF;
                if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'h8000_0000;
                return ia / ib;
            end
            3'd5: begin
                if (b == 0) return 32'hFFFF_FFFF;
                return a / b;
            end
            3'd6: begin
                if (b == 0) return a;
                if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'h0;
                return ia % ib;
            end
            default: begin
                if (b == 0) return a;
                return 32'(ua % ub);
            end
        endcase
    endfunction

    function automatic int ref_lat(input logic [2:0] op, input logic [31:0] a,
                                   input logic [31:0] b);
        if (op < 3'd4) return 3;
        if (b == 0) return 2;
        if (!op[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 2;
        return 34;
    endfunction

    // Hold the instruction in E until DoneMD, then return one cycle later
    // (the IDLE cycle after DONE) with startE still high.
    task automatic run_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                          output logic [31:0] res, output int lat, output int stalls);
        bit got;
        got    = 0;
        res    = 'x;
        lat    = 0;
        stalls = 0;
        startE  = 1'b1;
        funct3E = op;
        SrcAE   = a;
        SrcBE   = b;
        for (int c = 1; c <= 40; c++) begin
            #1;
            if (DoneMD) begin
                res = ResultMD;
                lat = c;
                got = 1;
                if (StallMD) stalls++;
            end else if (StallMD) begin
                stalls++;
            end
            @(posedge clk);
            #1;
            if (got) break;
        end
        if (!got) begin
            n_checks++;
            $display("FAIL timeout: no DoneMD within 40 cycles for op %0d", op);
        end
    endtask

    task automatic run_and_check(input string name, input logic [2:0] op,
                                 input logic [31:0] a, input logic [31:0] b,
                                 input logic [31:0] exp_res, input int exp_lat);
        logic [31:0] r;
        int          l, s;
        run_op(op, a, b, r, l, s);
        check({name, " result"}, r, exp_res);
        check({name, " latency"}, 32'(l), 32'(exp_lat));
        check({name, " stall cycles"}, 32'(s), 32'(exp_lat - 1));
    endtask

    task automatic idle_cycles(input int n);
        startE = 1'b0;
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    initial begin
        vec_t        tbl[10];
        logic [31:0] r, held;
        logic [2:0]  op;
        logic [31:0] a, b;
        int          l, s, d0;

        n_checks = 0;
        n_pass   = 0;
        done_cnt = 0;

        tbl[0] = '{3'd1, 32'hFFFF_FFFE, 32'h0000_0003, 32'hFFFF_FFFF, 3};
        tbl[1] = '{3'd4, 32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFD, 34};
        tbl[2] = '{3'd6, 32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFF, 34};
        tbl[3] = '{3'd5, 32'd100,       32'd0,         32'hFFFF_FFFF, 2};
        tbl[4] = '{3'd7, 32'd100,       32'd0,         32'd100,       2};
        tbl[5] = '{3'd4, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 2};
        tbl[6] = '{3'd6, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 2};
        tbl[7] = '{3'd0, 32'd6,         32'd7,         32'd42,        3};
        tbl[8] = '{3'd2, 32'hFFFF_FFFF, 32'h0000_0002, 32'hFFFF_FFFF, 3};
        tbl[9] = '{3'd5, 32'hFFFF_FFFF, 32'h0000_0010, 32'h0FFF_FFFF, 34};

        // Reset with startE high: nothing may stall or complete.
        rst     = 1'b0;
        killE   = 1'b0;
        startE  = 1'b1;
        funct3E = 3'd4;
        SrcAE   = 32'd50;
        SrcBE   = 32'd3;
        @(posedge clk);
        @(posedge clk);
        #1;
        check("reset ResultMD", ResultMD, 32'h0);
        check("reset DoneMD", {31'h0, DoneMD}, 32'h0);
        check("reset StallMD masked", {31'h0, StallMD}, 32'h0);
        startE = 1'b0;
        rst    = 1'b1;
        idle_cycles(2);
        check("idle StallMD", {31'h0, StallMD}, 32'h0);

        // Directed table.
        for (int i = 0; i < 10; i++) begin
            run_and_check($sformatf("vec%0d", i), tbl[i].op, tbl[i].a, tbl[i].b,
                          tbl[i].res, tbl[i].lat);
            idle_cycles(1);
        end

        // Back-to-back: second op accepted in the IDLE cycle after DONE.
        d0 = done_cnt;
        run_and_check("b2b mulhu", 3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 3);
        run_and_check("b2b divu", 3'd5, 32'h0000_000A, 32'd3, 32'd3, 34);
        idle_cycles(3);
        check("b2b done pulses", 32'(done_cnt - d0), 32'd2);

        // Kill at DIV iteration 10.
        held = ResultMD;
        d0   = done_cnt;
        startE  = 1'b1;
        funct3E = 3'd4;
        SrcAE   = 32'd1000;
        SrcBE   = 32'd7;
        for (int i = 0; i < 11; i++) begin
            @(posedge clk);
            #1;
        end
        killE = 1'b1;
        #1;
        check("kill StallMD", {31'h0, StallMD}, 32'h0);
        check("kill DoneMD", {31'h0, DoneMD}, 32'h0);
        @(posedge clk);
        #1;
        killE  = 1'b0;
        startE = 1'b0;
        #1;
        check("after kill StallMD", {31'h0, StallMD}, 32'h0);
        check("after kill ResultMD held", ResultMD, held);
        idle_cycles(40);
        check("kill no DoneMD", 32'(done_cnt - d0), 32'd0);
        check("kill ResultMD still held", ResultMD, held);
        run_and_check("post-kill mul", 3'd0, 32'd6, 32'd7, 32'd42, 3);
        idle_cycles(1);

        // Reset at DIV iteration 20.
        d0 = done_cnt;
        startE  = 1'b1;
        funct3E = 3'd5;
        SrcAE   = 32'hDEAD_BEEF;
        SrcBE   = 32'd13;
        for (int i = 0; i < 21; i++) begin
            @(posedge clk);
            #1;
        end
        rst    = 1'b0;
        startE = 1'b0;
        @(posedge clk);
        #1;
        check("mid-div rst ResultMD", ResultMD, 32'h0);
        check("mid-div rst DoneMD", {31'h0, DoneMD}, 32'h0);
        check("mid-div rst StallMD", {31'h0, StallMD}, 32'h0);
        @(posedge clk);
        #1;
        rst = 1'b1;
        idle_cycles(40);
        check("mid-div rst no DoneMD", 32'(done_cnt - d0), 32'd0);
        check("mid-div rst ResultMD stays 0", ResultMD, 32'h0);

        // Random ops against the reference model.
        for (int i = 0; i < 60; i++) begin
            op = 3'($urandom_range(0, 7));
            a  = $urandom;
            case ($urandom_range(0, 9))
                0:       b = 32'h0;
                1:       begin a = 32'h8000_0000; b = 32'hFFFF_FFFF; end
                2, 3:    b = 32'($urandom_range(1, 20));
                4:       b = 32'hFFFF_FFFF;
                default: b = $urandom;
            endcase
            run_op(op, a, b, r, l, s);
            check($sformatf("rand%0d op%0d 0x%08h,0x%08h result", i, op, a, b), r,
                  ref_res(op, a, b));
            check($sformatf("rand%0d latency", i), 32'(l), 32'(ref_lat(op, a, b)));
            if ($urandom_range(0, 1) == 1) idle_cycles(1);
        end

        idle_cycles(2);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
